// File: rtl/branch_unit_ras_if.sv
// Decode/regfile/ALU-facing bundle of the branch/PC unit.
// The unit drives through the slave modport; whatever feeds it uses master.
interface branch_unit_ras_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned OP_W    = 5;
  localparam int unsigned LABEL_W = 26;
  localparam int unsigned COMP_W  = 21;

  logic               stall;
  logic [OP_W-1:0]    br_op;
  logic [LABEL_W-1:0] label_addr;
  logic [COMP_W-1:0]  comp_addr;
  logic [XLEN-1:0]    inreg;
  logic               carry;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_next;
  logic [XLEN-1:0]    pc_branch_link;
  logic               taken;
  logic               ras_overflow;
  logic               ras_underflow;

  modport master (
    output stall, br_op, label_addr, comp_addr, inreg, carry,
    input  pc, pc_next, pc_branch_link, taken, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, br_op, label_addr, comp_addr, inreg, carry,
    output pc, pc_next, pc_branch_link, taken, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/branch_unit_ras.sv
// Architectural PC register with same-cycle branch resolution and optional return-address stack.
// Define BRANCH_RAS_EN to build the RAS; otherwise call is jump-and-link and return jumps to inreg.
module branch_unit_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(0)
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_unit_ras_if.slave      bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_c, lab_c, cmp_c;
  logic [XLEN-1:0] pc_next_c, link_c;
  logic            taken_c;
  logic            push_c, pop_c;

`ifdef BRANCH_RAS_EN
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_c, full_c;
  logic [XLEN-1:0]  ras_top_c;

  assign empty_c   = (cnt_q == CNT_W'(0));
  assign full_c    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top_c = ras_q[ptr_q - PTR_W'(1)];
`endif

  assign seq_c = pc_q + XLEN'(4);
  assign lab_c = {pc_q[XLEN-1:28], bus.label_addr, 2'b00};
  assign cmp_c = {pc_q[XLEN-1:23], bus.comp_addr, 2'b00};

  // Target select; taken marks any source other than the sequential one.
  always_comb begin
    pc_next_c = seq_c;
    taken_c   = 1'b0;
    link_c    = XLEN'(0);
    push_c    = 1'b0;
    pop_c     = 1'b0;
    unique case (bus.br_op[2:0])
      3'b001: begin pc_next_c = lab_c;     taken_c = 1'b1; end
      3'b010: begin pc_next_c = bus.inreg; taken_c = 1'b1; end
      3'b011: begin
        unique case (bus.br_op[4:3])
          2'b00:   taken_c = bus.inreg[XLEN-1];
          2'b01:   taken_c = (bus.inreg == XLEN'(0));
          2'b10:   taken_c = (bus.inreg != XLEN'(0));
          default: taken_c = 1'b0;
        endcase
        if (taken_c) pc_next_c = cmp_c;
      end
      3'b100: begin
        taken_c = bus.br_op[3] ^ bus.carry;
        if (taken_c) pc_next_c = lab_c;
      end
      3'b101: begin
        pc_next_c = lab_c;
        taken_c   = 1'b1;
        link_c    = seq_c;
`ifdef BRANCH_RAS_EN
        push_c    = 1'b1;
`endif
      end
      3'b110: begin
`ifdef BRANCH_RAS_EN
        pop_c = 1'b1;
        if (!empty_c) begin
          pc_next_c = ras_top_c;
          taken_c   = 1'b1;
        end
`else
        pc_next_c = bus.inreg;
        taken_c   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Next state for PC and stack bookkeeping; stall freezes everything.
  always_comb begin
    pc_d = bus.stall ? pc_q : pc_next_c;
`ifdef BRANCH_RAS_EN
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!bus.stall) begin
      if (push_c) begin
        ptr_d = ptr_q + PTR_W'(1);
        if (full_c) ovf_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_c) begin
        if (empty_c) begin
          unf_d = 1'b1;
        end else begin
          ptr_d = ptr_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

`ifdef BRANCH_RAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_W'(0);
      cnt_q <= CNT_W'(0);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_c && !bus.stall) ras_q[ptr_q] <= seq_c;
  end

  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
`else
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  assign bus.pc             = pc_q;
  assign bus.pc_next        = pc_next_c;
  assign bus.pc_branch_link = link_c;
  assign bus.taken          = taken_c;

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
- Sequential, parametrised next-generation branch/PC unit for the mini-RISC core.
- Owns the architectural PC register and resolves the same 5-bit branch opcode as the current combinational branch logic.
- Adds a stall handshake and a DEPTH-entry return-address stack (RAS) for call/return.
- Sits between decode (br_op, address fields), the register file (inreg, link write) and the ALU carry flag.

Parameters:
- XLEN, 32, datapath/PC width. Must be >= 32.
- RAS_DEPTH, 4, RAS entries. Must be a power of 2, >= 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- br_op  in  5  branch opcode.
- label_addr  in  26  jump/call word address.
- comp_addr  in  21  compare-branch word address.
- inreg  in  XLEN  register operand, signed.
- carry  in  1  ALU carry flag.
- pc  out  XLEN  current PC (registered).
- pc_next  out  XLEN  combinational next PC.
- pc_branch_link  out  XLEN  link value (combinational).
- taken  out  1  pc_next != pc+4 path selected (combinational).
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: pop while empty.

Behaviour:
- Targets:
  - seq = pc+4, modulo 2^XLEN.
  - lab = {pc[XLEN-1:28], label_addr, 2'b00}.
  - cmp = {pc[XLEN-1:23], comp_addr, 2'b00}.
  - reg = inreg.
- br_op[2:0] decode:
  - 000: seq.
  - 001: lab.
  - 010: reg.
  - 011: compare branch, sub-op br_op[4:3]:
    - 00: cmp if inreg<0 (signed).
    - 01: cmp if inreg==0.
    - 10: cmp if inreg!=0.
    - 11: seq.
  - 100: lab if (br_op[3]^carry), else seq.
  - 101: call. lab, and push seq onto RAS.
  - 110: return. Pop RAS top into PC. If RAS empty: seq, and set ras_underflow.
  - 111: seq.
- pc_branch_link: seq when br_op[2:0]==101, else 0. Independent of stall.
- taken: 1 whenever the selected source is not seq.
- Clocked update:
  - On rising clk with stall=0: pc <= pc_next, and any push/pop takes effect.
  - stall=1: pc, RAS and flags hold. pc_next and taken still reflect current inputs.
- Latency: branch resolved same cycle, visible on pc one clock later. No delay slot.
- RAS: circular buffer, top pointer (log2 RAS_DEPTH bits) plus count (0..RAS_DEPTH).
  - Push when not full: write entry, increment pointer and count.
  - Push when full: overwrite oldest (pointer wraps), count stays RAS_DEPTH, ras_overflow <= 1.
  - Pop when count>0: read top, decrement pointer and count.
  - Pop when empty: no pointer change, ras_underflow <= 1.
  - Push and pop never coincide (single opcode per cycle).
- Flags: sticky until reset.
- Reset (async, any time, including mid-stall):
  - pc = RESET_PC, count = 0, pointer = 0, both flags = 0.
  - RAS contents don't-care.
  - First fetch after reset release uses RESET_PC.
- Wrap: pc+4 from all-ones-minus-3 wraps to 0. No trap.

Optional Feature:
- Macro: BRANCH_RAS_EN.
- Defined: RAS built as above. 110 performs return-from-stack.
- Undefined:
  - No RAS storage.
  - 101 is plain jump-and-link (lab, link out, no push).
  - 110 behaves as 010 (pc_next = inreg).
  - ras_overflow and ras_underflow tied 0.

Test Plan:
- Reset: rst=1 with RESET_PC=0x100, then release, br_op=000 for 3 cycles -> pc 0x100, 0x104, 0x108, 0x10C. Flags 0.
- Compare branch: pc=0x00400000, br_op=01011, comp_addr=0x10, inreg=0 -> taken=1, next pc=0x00000040. Repeat with inreg=5 -> pc=0x00400004.
- Carry branch: br_op=00100, carry=1 -> lab taken. br_op=01100, carry=1 -> seq.
- Call/return: pc=0x200, br_op=101, label_addr=0x80 -> pc_branch_link=0x204, pc becomes 0x200. Then br_op=110 -> pc=0x204, count 0.
- RAS wrap (DEPTH=4): 5 calls then 5 returns -> ras_overflow=1, first 4 returns give most recent links in LIFO order, 5th pops empty -> seq and ras_underflow=1.
- Stall and async reset: stall=1 with br_op=001 -> pc unchanged, taken=1. Assert rst mid-cycle -> pc immediately RESET_PC, without waiting for clk.
